// File: rtl/if_stream_writer_if.sv
// Memory-read and IF-buffer write bus for the IF stream writer.
// The master side is the writer: it issues reads and pushes packed words.
interface if_stream_writer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int PAR_WRITE  = 2,
    parameter int ADDR_LEN   = 8
);
    logic                                  mem_ren;
    logic [ADDR_LEN-1:0]                   mem_addr;
    logic [DATA_WIDTH-1:0]                 mem_rdata;
    logic                                  fifo_full;
    logic                                  fifo_wen;
    logic [PAR_WRITE*(DATA_WIDTH+2)-1:0]   fifo_din;

    modport master (
        output mem_ren, mem_addr, fifo_wen, fifo_din,
        input  mem_rdata, fifo_full
    );

    modport slave (
        input  mem_ren, mem_addr, fifo_wen, fifo_din,
        output mem_rdata, fifo_full
    );
endinterface

// File: rtl/if_stream_writer.sv
// IF stream writer: reads row_count x row_len elements from feature memory,
// packs PAR_WRITE tagged elements {sor, eor, data} per IF FIFO write word.
module if_stream_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int PAR_WRITE  = 2,
    parameter int ADDR_LEN   = 8,
    parameter int LEN_W      = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [ADDR_LEN-1:0]  base_addr,
    input  logic [LEN_W-1:0]     row_len,
    input  logic [LEN_W-1:0]     row_count,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    if_stream_writer_if.master   wr
);
    localparam int unsigned LW     = DATA_WIDTH + 2;
    localparam int unsigned LANE_W = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1;
    localparam logic [LEN_W:0]    PW_EXT   = (LEN_W+1)'(PAR_WRITE);
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(PAR_WRITE - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LAST, PUSH, DONE} state_t;

    state_t                        r_state;
    logic [LEN_W-1:0]              r_len;
    logic [LEN_W-1:0]              r_cnt;
    logic [LEN_W-1:0]              r_row;
    logic [LEN_W-1:0]              r_word_col;
    logic [LANE_W-1:0]             r_lane;
    logic                          r_mem_ren;
    logic [ADDR_LEN-1:0]           r_mem_addr;
    logic [PAR_WRITE*LW-1:0]       r_pack;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_err;

    logic                          w_reject;
    logic                          w_row_end;
    logic                          w_last_row;
    logic                          w_fifo_wen;
    logic                          w_cap_en;
    logic [LANE_W-1:0]             w_cap_idx;

    assign w_reject   = (row_len == '0) || (row_count == '0) ||
                        ((row_len % LEN_W'(PAR_WRITE)) != '0);
    assign w_row_end  = ({1'b0, r_word_col} + PW_EXT) == {1'b0, r_len};
    assign w_last_row = ({1'b0, r_row} + (LEN_W+1)'(1)) == {1'b0, r_cnt};
    assign w_fifo_wen = (r_state == PUSH) && !wr.fifo_full;

    assign wr.mem_ren  = r_mem_ren;
    assign wr.mem_addr = r_mem_addr;
    assign wr.fifo_wen = w_fifo_wen;
    assign wr.fifo_din = r_pack;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

    // Read data lags its strobe by one cycle, so the lane being filled trails the lane being read.
    always_comb begin
        w_cap_en  = 1'b0;
        w_cap_idx = '0;
        if (r_state == FETCH && r_lane != '0) begin
            w_cap_en  = 1'b1;
            w_cap_idx = r_lane - LANE_W'(1);
        end else if (r_state == LAST) begin
            w_cap_en  = 1'b1;
            w_cap_idx = LANE_MAX;
        end
    end

    // Pack register: capture each returned element with its row tags into its lane.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pack <= '0;
        end else if (w_cap_en) begin
            for (int unsigned k = 0; k < PAR_WRITE; k++) begin
                if (LANE_W'(k) == w_cap_idx) begin
                    r_pack[k*LW +: LW] <= {(k == 0) && (r_word_col == '0),
                                           (k == PAR_WRITE - 1) && w_row_end,
                                           wr.mem_rdata};
                end
            end
        end
    end

    // Control FSM: job acceptance, read issue, word push with backpressure, completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
            r_row      <= '0;
            r_word_col <= '0;
            r_lane     <= '0;
            r_mem_ren  <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len      <= row_len;
                        r_cnt      <= row_count;
                        r_row      <= '0;
                        r_word_col <= '0;
                        r_lane     <= '0;
                        r_busy     <= 1'b1;
                        if (w_reject) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state    <= FETCH;
                            r_mem_ren  <= 1'b1;
                            r_mem_addr <= base_addr;
                        end
                    end
                end
                FETCH: begin
                    // Address always advances, so it already points at the next word's first element.
                    r_mem_addr <= r_mem_addr + ADDR_LEN'(1);
                    if (r_lane == LANE_MAX) begin
                        r_state   <= LAST;
                        r_mem_ren <= 1'b0;
                        r_lane    <= '0;
                    end else begin
                        r_lane <= r_lane + LANE_W'(1);
                    end
                end
                LAST: begin
                    r_state <= PUSH;
                end
                PUSH: begin
                    if (!wr.fifo_full) begin
                        if (w_row_end) begin
                            r_word_col <= '0;
                            r_row      <= r_row + LEN_W'(1);
                        end else begin
                            r_word_col <= r_word_col + LEN_W'(PAR_WRITE);
                        end
                        if (w_row_end && w_last_row) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= FETCH;
                            r_mem_ren <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_stream_writer.sv
// Directed bench for if_stream_writer: packing/tags, timing, backpressure,
// rejection, address wrap and asynchronous reset.
module tb_if_stream_writer;
    localparam int DW = 16;
    localparam int PW = 2;
    localparam int AW = 8;
    localparam int LN = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LN-1:0] row_len = '0;
    logic [LN-1:0] row_count = '0;
    logic          busy, done, err;

    int unsigned   cyc = 0;
    int            errors = 0;
    int            checks = 0;

    logic [35:0]   wq[$];
    int unsigned   wc[$];
    logic [7:0]    aq[$];

    if_stream_writer_if #(.DATA_WIDTH(DW), .PAR_WRITE(PW), .ADDR_LEN(AW)) sif ();

    if_stream_writer #(.DATA_WIDTH(DW), .PAR_WRITE(PW), .ADDR_LEN(AW), .LEN_W(LN)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .row_len   (row_len),
        .row_count (row_count),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wr        (sif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Feature memory: mem[a] = a, data one cycle after the strobe.
    always @(posedge clk) if (sif.mem_ren) sif.mem_rdata <= {8'h00, sif.mem_addr};

    // Record every FIFO write and memory read, sampled after the falling edge.
    always begin
        @(negedge clk);
        #2;
        if (sif.fifo_wen === 1'b1) begin
            wq.push_back(sif.fifo_din);
            wc.push_back(cyc);
        end
        if (sif.mem_ren === 1'b1) aq.push_back(sif.mem_addr);
    end

    function automatic logic [35:0] mkw(input logic s0, input logic [15:0] d0,
                                        input logic e1, input logic [15:0] d1);
        return {1'b0, e1, d1, s0, 1'b0, d0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input logic [7:0] b, input logic [7:0] l, input logic [7:0] c,
                           output int unsigned sc);
        @(negedge clk);
        base_addr = b;
        row_len   = l;
        row_count = c;
        start     = 1'b1;
        sc        = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int unsigned dc);
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            #3;
            if (done === 1'b1) break;
        end
        chk("done_seen", 64'(n < 300), 64'd1);
        dc = cyc;
    endtask

    logic [35:0] exp1 [4];
    logic [35:0] exp3 [3];
    logic [7:0]  expa [4];

    initial begin
        int unsigned sc, dc, wb, ab;

        exp1[0] = mkw(1'b1, 16'h0010, 1'b0, 16'h0011);
        exp1[1] = mkw(1'b0, 16'h0012, 1'b1, 16'h0013);
        exp1[2] = mkw(1'b1, 16'h0014, 1'b0, 16'h0015);
        exp1[3] = mkw(1'b0, 16'h0016, 1'b1, 16'h0017);
        exp3[0] = mkw(1'b1, 16'h0020, 1'b1, 16'h0021);
        exp3[1] = mkw(1'b1, 16'h0022, 1'b1, 16'h0023);
        exp3[2] = mkw(1'b1, 16'h0024, 1'b1, 16'h0025);
        expa[0] = 8'hFE; expa[1] = 8'hFF; expa[2] = 8'h00; expa[3] = 8'h01;

        // Reset values
        sif.fifo_full = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_wen",  64'(sif.fifo_wen), 64'd0);
        chk("rst_ren",  64'(sif.mem_ren),  64'd0);
        chk("rst_busy", 64'(busy),         64'd0);
        chk("rst_done", 64'(done),         64'd0);
        chk("rst_err",  64'(err),          64'd0);
        chk("rst_addr", 64'(sif.mem_addr), 64'd0);
        chk("rst_din",  64'(sif.fifo_din), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Default job, never full
        wb = wq.size(); ab = aq.size();
        run_job(8'h10, 8'd4, 8'd2, sc);
        #3 chk("s1_busy", 64'(busy), 64'd1);
        wait_done(dc);
        chk("s1_done_cyc", 64'(dc - sc), 64'd17);
        chk("s1_err", 64'(err), 64'd0);
        chk("s1_nwr", 64'(wq.size() - wb), 64'd4);
        chk("s1_nrd", 64'(aq.size() - ab), 64'd8);
        for (int i = 0; i < 4; i++) begin
            chk("s1_word", 64'(wq[wb+i]), 64'(exp1[i]));
            chk("s1_wcyc", 64'(wc[wb+i] - sc), 64'(4 + 4*i));
        end
        @(negedge clk);
        #3;
        chk("s1_done_low", 64'(done), 64'd0);
        chk("s1_busy_low", 64'(busy), 64'd0);

        // Same job with full raised on PUSH entry for 5 cycles
        wb = wq.size(); ab = aq.size();
        run_job(8'h10, 8'd4, 8'd2, sc);
        repeat (3) @(negedge clk);
        sif.fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("s2_wen_held", 64'(sif.fifo_wen), 64'd0);
            chk("s2_ren_held", 64'(sif.mem_ren),  64'd0);
            chk("s2_din_held", 64'(sif.fifo_din), 64'(exp1[0]));
            @(negedge clk);
        end
        sif.fifo_full = 1'b0;
        wait_done(dc);
        chk("s2_done_cyc", 64'(dc - sc), 64'd22);
        chk("s2_nwr", 64'(wq.size() - wb), 64'd4);
        chk("s2_nrd", 64'(aq.size() - ab), 64'd8);
        for (int i = 0; i < 4; i++) begin
            chk("s2_word", 64'(wq[wb+i]), 64'(exp1[i]));
            chk("s2_wcyc", 64'(wc[wb+i] - sc), 64'(9 + 4*i));
        end

        // Two-element rows: every word carries both tags
        wb = wq.size();
        run_job(8'h20, 8'd2, 8'd3, sc);
        wait_done(dc);
        chk("s3_done_cyc", 64'(dc - sc), 64'd13);
        chk("s3_nwr", 64'(wq.size() - wb), 64'd3);
        for (int i = 0; i < 3; i++) chk("s3_word", 64'(wq[wb+i]), 64'(exp3[i]));

        // Rejected job: row_len not a multiple of PAR_WRITE
        wb = wq.size(); ab = aq.size();
        run_job(8'h10, 8'd3, 8'd2, sc);
        #3;
        chk("s4_done", 64'(done), 64'd1);
        chk("s4_err",  64'(err),  64'd1);
        @(negedge clk);
        #3;
        chk("s4_done_low", 64'(done), 64'd0);
        chk("s4_err_low",  64'(err),  64'd0);
        chk("s4_busy_low", 64'(busy), 64'd0);
        chk("s4_nwr", 64'(wq.size() - wb), 64'd0);
        chk("s4_nrd", 64'(aq.size() - ab), 64'd0);

        // Address wrap
        wb = wq.size(); ab = aq.size();
        run_job(8'hFE, 8'd4, 8'd1, sc);
        wait_done(dc);
        chk("s5_done_cyc", 64'(dc - sc), 64'd9);
        chk("s5_nrd", 64'(aq.size() - ab), 64'd4);
        for (int i = 0; i < 4; i++) chk("s5_addr", 64'(aq[ab+i]), 64'(expa[i]));
        chk("s5_word0", 64'(wq[wb]),   64'(mkw(1'b1, 16'h00FE, 1'b0, 16'h00FF)));
        chk("s5_word1", 64'(wq[wb+1]), 64'(mkw(1'b0, 16'h0000, 1'b1, 16'h0001)));

        // Asynchronous reset mid-PUSH, then start ignored while busy
        wb = wq.size();
        run_job(8'h10, 8'd4, 8'd2, sc);
        repeat (3) @(negedge clk);
        #1 rstn = 1'b0;
        #2;
        chk("s6_wen",  64'(sif.fifo_wen), 64'd0);
        chk("s6_ren",  64'(sif.mem_ren),  64'd0);
        chk("s6_busy", 64'(busy),         64'd0);
        chk("s6_done", 64'(done),         64'd0);
        chk("s6_din",  64'(sif.fifo_din), 64'd0);
        chk("s6_addr", 64'(sif.mem_addr), 64'd0);
        chk("s6_nwr",  64'(wq.size() - wb), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        chk("s6_idle_nwr", 64'(wq.size() - wb), 64'd0);
        chk("s6_idle_busy", 64'(busy), 64'd0);

        wb = wq.size();
        run_job(8'h10, 8'd4, 8'd2, sc);
        @(negedge clk);
        base_addr = 8'h80;
        row_len   = 8'd2;
        row_count = 8'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(dc);
        chk("s6_done_cyc", 64'(dc - sc), 64'd17);
        chk("s6_job_nwr", 64'(wq.size() - wb), 64'd4);
        for (int i = 0; i < 4; i++) chk("s6_word", 64'(wq[wb+i]), 64'(exp1[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_stream_writer.md
# if_stream_writer

Feeds the IF input-feature FIFO from a word-addressed feature memory. On `start` it reads `row_count` rows of `row_len` elements starting at `base_addr`. It packs `PAR_WRITE` elements into one FIFO write word and tags each element with start-of-row and end-of-row bits. It sits upstream of the IF buffer, driving that buffer's `wen`/`din` and honouring its `full`. This is the writer side of the tagged-element stream that the convolution datapath consumes.

## Interface
- `DATA_WIDTH`, 16, element width (matches IF scratch width).
- `PAR_WRITE`, 2, elements per FIFO write word (matches IF buffer PAR_WRITE).
- `ADDR_LEN`, 8, feature-memory address width.
- `LEN_W`, 8, width of `row_len` / `row_count`.

- `clk`  in  1  single clock; all state on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_LEN  first element address; latched on accepted start.
- `row_len`  in  LEN_W  elements per row; latched on accepted start.
- `row_count`  in  LEN_W  number of rows; latched on accepted start.
- `mem_ren`  out  1  memory read strobe.
- `mem_addr`  out  ADDR_LEN  memory read address.
- `mem_rdata`  in  DATA_WIDTH  read data, valid the cycle after `mem_ren`.
- `fifo_full`  in  1  IF buffer full.
- `fifo_wen`  out  1  IF buffer write enable.
- `fifo_din`  out  PAR_WRITE*(DATA_WIDTH+2)  packed tagged elements.
- `busy`  out  1  high from accepted start until DONE.
- `done`  out  1  one-cycle pulse at end of job.
- `err`  out  1  one-cycle pulse with `done` when the job is rejected.

## Operation
- Lane k occupies `fifo_din[(k+1)*(DATA_WIDTH+2)-1 : k*(DATA_WIDTH+2)]`. Lane 0 is the first element in stream order.
- Lane format: `{sor, eor, data}`. `sor` is the MSB; `eor` is bit `DATA_WIDTH`.
- `sor` = 1 only on lane 0 of the first word of each row.
- `eor` = 1 only on lane `PAR_WRITE-1` of the last word of each row.
- All other tag bits are 0.
- Addresses increment by 1 per element, continuously across rows, starting at `base_addr`. They wrap modulo 2^ADDR_LEN.
- Job rejection: `row_len` = 0, `row_count` = 0, or `row_len` not a multiple of `PAR_WRITE`.
  - Rejected jobs go IDLE -> DONE with `err` = 1.
  - No memory reads and no FIFO writes occur.
- FSM states: IDLE, FETCH, LAST, PUSH, DONE.
  - IDLE: `start` = 1 latches the inputs. Go to FETCH, or to DONE if the job is rejected.
  - FETCH: `mem_ren` = 1 and `mem_addr` = current address on each of `PAR_WRITE` consecutive cycles. Each returned element is captured into the next lane one cycle later. After the read for lane `PAR_WRITE-1` is issued, go to LAST.
  - LAST: capture the final lane; `mem_ren` = 0. Go to PUSH.
  - PUSH: `fifo_wen` = !`fifo_full` (combinational in this state only). On a cycle with `fifo_wen` = 1, go to FETCH if elements remain, else go to DONE.
  - DONE: `done` = 1 for one cycle. Go to IDLE.
- `fifo_din` is registered and held stable throughout PUSH.
- `start` in any state other than IDLE is ignored.
- Reset at any time forces IDLE. All counters, the pack register and latched parameters clear.

## Timing
- Reset values: `mem_ren`, `fifo_wen`, `busy`, `done`, `err` = 0; `mem_addr` = 0; `fifo_din` = 0.
- Reset acts asynchronously, so `fifo_wen` drops in the same cycle `rstn` falls.
- Per word, with `fifo_full` = 0: `PAR_WRITE` + 2 cycles (FETCH×PAR_WRITE, LAST, PUSH).
- Example, `PAR_WRITE` = 2: the first write occurs 4 cycles after the `start` edge.
- `done` is asserted the cycle after the final write.
- `busy` falls together with `done` going low.
- Backpressure: each cycle of `fifo_full` = 1 in PUSH adds one cycle. No memory reads are issued while waiting.
- `fifo_full` rising in the same cycle PUSH is entered: no write that cycle.

## Test plan
- Defaults, `base_addr` = 0x10, `row_len` = 4, `row_count` = 2, mem[a] = a, never full -> 4 writes, one every 4 cycles, each shown lane0 / lane1:
  - {sor,0x10} / {0x11}
  - {0x12} / {eor,0x13}
  - {sor,0x14} / {0x15}
  - {0x16} / {eor,0x17}
  - then `done` pulse, `busy` low, `err` = 0.
- Same job, `fifo_full` held high 5 cycles on entry to the first PUSH -> no `fifo_wen`, no `mem_ren`, `fifo_din` stable. The write happens in the first cycle full is low, and the sequence otherwise matches the first scenario.
- `row_len` = 2, `row_count` = 3 -> 3 words, each with lane0 `sor` = 1 and lane1 `eor` = 1.
- `row_len` = 3 -> `done` and `err` pulse 1 cycle after the start edge; zero `mem_ren` and zero `fifo_wen`.
- `ADDR_LEN` = 8, `base_addr` = 0xFE, `row_len` = 4, `row_count` = 1 -> `mem_addr` sequence 0xFE, 0xFF, 0x00, 0x01.
- `rstn` low mid-PUSH, then `start` pulses while busy after release -> all outputs 0 immediately. No further writes until a new `start` in IDLE. A `start` during a running job is ignored (write count unchanged).
